// File: rtl/video_timing_gen.sv
// Pixel timing generator: hsync/vsync/de decode, per-pixel requests to a pixel source,
// and a two-stage output pipeline that lines returned colour up with sync and de.
module video_timing_gen #(
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter logic        SYNC_POL = 1'b1
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic        timing_en,
    input  logic [23:0] pix_data,
    output logic        pix_req,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [7:0]  rgb_r,
    output logic [7:0]  rgb_g,
    output logic [7:0]  rgb_b,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [11:0] H_SYNC_C  = 12'(H_SYNC);
    localparam logic [11:0] H_ACT_S_C = 12'(H_SYNC + H_BP);
    localparam logic [11:0] H_ACT_E_C = 12'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [11:0] H_LAST_C  = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_SYNC_C  = 12'(V_SYNC);
    localparam logic [11:0] V_ACT_S_C = 12'(V_SYNC + V_BP);
    localparam logic [11:0] V_ACT_E_C = 12'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [11:0] V_LAST_C  = 12'(V_TOTAL - 1);

    if (H_ACTIVE > 1024 || V_ACTIVE > 1024) begin : g_chk_active
        $error("video_timing_gen: H_ACTIVE and V_ACTIVE must not exceed 1024");
    end
    if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_chk_total
        $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 4095");
    end

    logic        en_q;
    logic [11:0] cnt_h_q, cnt_h_d;
    logic [11:0] cnt_v_q, cnt_v_d;

    logic        s1_hs_q, s1_vs_q, s1_de_q, s1_fs_q;
    logic        s2_hs_q, s2_vs_q, s2_de_q, s2_fs_q;
    logic [23:0] rgb_q, rgb_d;

    logic run;
    logic h_act, v_act;
    logic dec_hs, dec_vs, dec_de, dec_fs;

    // en_q delays the first count by one edge so a fresh enable starts at (0,0);
    // gating with timing_en itself makes an abort take effect immediately.
    assign run = timing_en & en_q;

    always_comb begin
        cnt_h_d = cnt_h_q;
        cnt_v_d = cnt_v_q;
        if (!run) begin
            cnt_h_d = '0;
            cnt_v_d = '0;
        end else if (cnt_h_q == H_LAST_C) begin
            cnt_h_d = '0;
            cnt_v_d = (cnt_v_q == V_LAST_C) ? 12'd0 : cnt_v_q + 12'd1;
        end else begin
            cnt_h_d = cnt_h_q + 12'd1;
        end
    end

    always_comb begin
        h_act  = (cnt_h_q >= H_ACT_S_C) && (cnt_h_q < H_ACT_E_C);
        v_act  = (cnt_v_q >= V_ACT_S_C) && (cnt_v_q < V_ACT_E_C);
        dec_hs = run && (cnt_h_q < H_SYNC_C);
        dec_vs = run && (cnt_v_q < V_SYNC_C);
        dec_de = run && h_act && v_act;
        dec_fs = dec_de && (cnt_h_q == H_ACT_S_C) && (cnt_v_q == V_ACT_S_C);
    end

    assign pix_req = dec_de;
    assign pix_x   = dec_de ? 10'(cnt_h_q - H_ACT_S_C) : 10'd0;
    assign pix_y   = dec_de ? 10'(cnt_v_q - V_ACT_S_C) : 10'd0;

    // Source answers one clock after the request, i.e. while stage 1 holds that pixel.
    assign rgb_d = s1_de_q ? pix_data : 24'd0;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            en_q    <= 1'b0;
            cnt_h_q <= '0;
            cnt_v_q <= '0;
            s1_hs_q <= 1'b0;
            s1_vs_q <= 1'b0;
            s1_de_q <= 1'b0;
            s1_fs_q <= 1'b0;
            s2_hs_q <= 1'b0;
            s2_vs_q <= 1'b0;
            s2_de_q <= 1'b0;
            s2_fs_q <= 1'b0;
            rgb_q   <= '0;
        end else begin
            en_q    <= timing_en;
            cnt_h_q <= cnt_h_d;
            cnt_v_q <= cnt_v_d;
            s1_hs_q <= dec_hs;
            s1_vs_q <= dec_vs;
            s1_de_q <= dec_de;
            s1_fs_q <= dec_fs;
            s2_hs_q <= s1_hs_q;
            s2_vs_q <= s1_vs_q;
            s2_de_q <= s1_de_q;
            s2_fs_q <= s1_fs_q;
            rgb_q   <= rgb_d;
        end
    end

    // Sync registers hold "asserted"; polarity is applied on the way out.
    assign hsync       = s2_hs_q ? SYNC_POL : ~SYNC_POL;
    assign vsync       = s2_vs_q ? SYNC_POL : ~SYNC_POL;
    assign de          = s2_de_q;
    assign frame_start = s2_fs_q;
    assign rgb_r       = rgb_q[23:16];
    assign rgb_g       = rgb_q[15:8];
    assign rgb_b       = rgb_q[7:0];

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Pixel timing generator sitting directly upstream of the three TMDS channel encoders.
- Produces hsync, vsync and de, and issues per-pixel requests with x/y coordinates to a pixel source (pattern generator or frame-buffer read port).
- Registers the returned 24-bit RGB so colour, sync and de arrive at the encoders on the same cycle.
- Runs entirely in the pixel clock domain.

Parameters:
- H_SYNC, 96, hsync pulse width in clocks
- H_BP, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch
- SYNC_POL, 1'b1, asserted level of hsync/vsync (1 = active-high)

Ports:
- vga_clk  in  1  pixel clock
- sys_rst_n  in  1  asynchronous active-low reset
- timing_en  in  1  run enable; low holds the generator idle
- pix_data  in  24  {R,G,B} from source, valid exactly 1 clock after pix_req
- pix_req  out  1  request for pixel at (pix_x, pix_y) this cycle
- pix_x  out  10  column of requested pixel, 0 when pix_req low
- pix_y  out  10  row of requested pixel, 0 when pix_req low
- hsync  out  1  to encoder c0
- vsync  out  1  to encoder c1
- de  out  1  active video, to encoder de
- rgb_r / rgb_g / rgb_b  out  8 each  colour to the three encoders
- frame_start  out  1  one-clock pulse aligned with the first de of each frame

Behaviour:
- Reset: counters cleared; all outputs 0, except hsync/vsync, which go to ~SYNC_POL (deasserted).
- Counters:
  - cnt_h counts 0..H_TOTAL-1, where H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (default 800).
  - cnt_v counts 0..V_TOTAL-1, where V_TOTAL = 525 by default.
  - cnt_v advances only when cnt_h == H_TOTAL-1.
  - Both counters wrap to 0 on the same edge at frame end.
- Region order per line/frame: sync, back porch, active, front porch.
  - Sync: cnt_h < H_SYNC; cnt_v < V_SYNC.
  - Active: H_SYNC+H_BP <= cnt_h < H_SYNC+H_BP+H_ACTIVE, and the same form for v.
- pix_req:
  - Combinational from counters; high when the counter position is inside the active window.
  - pix_x = cnt_h-(H_SYNC+H_BP) and pix_y = cnt_v-(V_SYNC+V_BP) while pix_req is high, else 0.
- Pixel source contract: returns pix_data on the clock following pix_req. The block does not check this.
- Output pipeline, fixed latency 2 clocks from counter position to outputs:
  - Stage 1 registers the decoded hsync/vsync/de/frame-start.
  - Stage 2 registers them again, and registers pix_data into rgb_* gated by stage-1 de. rgb is 0 whenever de is 0.
- frame_start: high at stage 2 for position (x=0, y=0) only.
- timing_en low:
  - Counters held at 0 and stage-1 decode forced inactive.
  - After 2 clocks: de=0, rgb=0, syncs deasserted, pix_req=0.
  - Deassertion mid-frame aborts the frame immediately; no partial-line completion.
- timing_en rising: counting starts at (0,0) on the next edge, i.e. a fresh frame beginning with sync.
- Reset mid-frame: asynchronous return to reset values; restart as after power-up once released with timing_en high.
- Widths:
  - Counters are 12 bits; totals up to 4095 are supported.
  - pix_x/pix_y are 10 bits; H_ACTIVE and V_ACTIVE must be <= 1024. A parameter check errors at elaboration otherwise.
- No combinational path from pix_data to any output.

Test Plan:
- Reset then timing_en=1, defaults:
  - hsync high for exactly 96 clocks per 800-clock line.
  - vsync high for exactly 2 lines (1600 clocks) per 525-line frame.
  - Frame period 420000 clocks.
- Pixel request window:
  - First pix_req at cnt_h=144, cnt_v=35 with pix_x=0, pix_y=0.
  - Last at pix_x=639, pix_y=479.
  - 640 requests per active line; 307200 per frame.
- Data alignment:
  - Source returns {pix_x[7:0], pix_y[7:0], 8'hA5} one clock after each request.
  - Every de-high cycle must carry the matching coordinate pattern in rgb_r/rgb_g, and rgb_b = A5.
  - rgb=0 whenever de=0.
- frame_start:
  - Exactly one pulse per frame, coincident with first de.
  - Two consecutive pulses are 420000 clocks apart.
- Enable abort:
  - Drop timing_en at pix_x=300, pix_y=200. de/pix_req low within 2 clocks; syncs deasserted.
  - Re-raise it: next frame_start occurs 144+35*800 = 28144 clocks + 2 after the first enabled edge.
- SYNC_POL=0 with small parameters (H: 2/2/4/2, V: 1/1/3/1):
  - hsync low for 2 of 10 clocks; vsync low for 1 of 6 lines.
  - 12 de cycles per frame; counter wrap verified over 3 frames.
